// File: rtl/linkspeed_pkg.sv
// Shared message codes and state encoding for the MBTRAIN.LINKSPEED responders.
package linkspeed_pkg;

    localparam logic [3:0] NO_MSG                      = 4'd0;
    localparam logic [3:0] START_REQ                   = 4'd1;
    localparam logic [3:0] START_RESP                  = 4'd2;
    localparam logic [3:0] ERROR_REQ                   = 4'd3;
    localparam logic [3:0] ERROR_RESP                  = 4'd4;
    localparam logic [3:0] EXIT_TO_REPAIR_REQ          = 4'd5;
    localparam logic [3:0] EXIT_TO_REPAIR_RESP         = 4'd6;
    localparam logic [3:0] EXIT_TO_SPEED_DEGRADE_REQ   = 4'd7;
    localparam logic [3:0] EXIT_TO_SPEED_DEGRADE_RESP  = 4'd8;
    localparam logic [3:0] DONE_REQ                    = 4'd9;
    localparam logic [3:0] DONE_RESP                   = 4'd10;
    localparam logic [3:0] EXIT_TO_PHYRETRAIN_REQ      = 4'd11;
    localparam logic [3:0] EXIT_TO_PHYRETRAIN_RESP     = 4'd12;

    typedef enum logic [3:0] {
        IDLE       = 4'd0,
        WAIT_START = 4'd1,
        SEND_START = 4'd2,
        POINT_TEST = 4'd3,
        WAIT_ANY   = 4'd4,
        WAIT_RD    = 4'd5,
        SEND_LAST  = 4'd6,
        FINISH     = 4'd7,
        TIMEOUT    = 4'd8
    } state_t;

endpackage

// File: rtl/linkspeed_rx_param_sb_valid_arb.sv
// Sideband valid arbitration: holds a response as pending while the TX-side
// responder owns the sideband, raises valid when free, drops it when the
// sideband reports the message sent, and flags the valid falling edge.
module sb_valid_arb (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic load,
    input  logic tx_valid,
    input  logic busy_negedge,
    output logic valid,
    output logic valid_fall
);

    logic pending_reg;
    logic valid_reg;
    logic valid_d_reg;
    logic want_send;
    logic do_set;

    // A freshly loaded message can go out on the very edge it is loaded.
    assign want_send  = load | pending_reg;
    // Busy-negedge wins over a set in the same cycle; the message stays pending.
    assign do_set     = want_send & ~tx_valid & ~busy_negedge;
    assign valid      = valid_reg;
    assign valid_fall = valid_d_reg & ~valid_reg;

    // Pending flag, valid register and its delayed copy for edge detection.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            pending_reg <= 1'b0;
            valid_reg   <= 1'b0;
            valid_d_reg <= 1'b0;
        end else begin
            pending_reg <= want_send & ~do_set;
            valid_d_reg <= valid_reg;
            if (busy_negedge) begin
                valid_reg <= 1'b0;
            end else if (do_set) begin
                valid_reg <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/linkspeed_rx_param.sv
// Receiver-side MBTRAIN.LINKSPEED responder: answers partner sideband
// requests, runs the local point test, reduces lane results to group flags
// and enforces a wait-state timeout.
module linkspeed_rx_param
    import linkspeed_pkg::*;
#(
    parameter int NUM_LANES      = 16,
    parameter int GROUP_W        = 8,
    parameter int TIMEOUT_CYCLES = 8000,
    localparam int NUM_GROUPS    = NUM_LANES / GROUP_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_en,
    input  logic [3:0]            i_sideband_message,
    input  logic                  i_sideband_valid,
    input  logic                  i_tx_valid,
    input  logic                  i_busy_negedge_detected,
    input  logic                  i_point_test_ack,
    input  logic [NUM_LANES-1:0]  i_lanes_result,
    input  logic                  i_valid_framing_error,
    input  logic                  i_comming_from_repair,
    input  logic [NUM_GROUPS-1:0] i_tx_group_ok,
    output logic [3:0]            o_sideband_message,
    output logic                  o_valid_rx,
    output logic                  o_point_test_en,
    output logic                  o_test_ack,
    output logic                  o_timeout,
    output logic [NUM_GROUPS-1:0] o_group_ok
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t                state_reg;
    state_t                state_next;
    logic [CNT_W-1:0]      cnt_reg;
    logic [3:0]            msg_reg;
    logic [NUM_GROUPS-1:0] group_ok_reg;
    logic [NUM_GROUPS-1:0] group_pass;

    logic       load_msg;
    logic       load_valid;
    logic [3:0] msg_next;
    logic       latch_groups;
    logic       counting;
    logic       valid_fall;
    logic       req_valid;
    logic       repair_ok;
    logic       healthy;

    // A group passes only when every lane in it passes.
    generate
        for (genvar gi = 0; gi < NUM_GROUPS; gi++) begin : g_group
            assign group_pass[gi] = &i_lanes_result[gi*GROUP_W +: GROUP_W];
        end
    endgenerate

    assign req_valid = i_sideband_valid;
    assign repair_ok = i_comming_from_repair & |(i_tx_group_ok & group_ok_reg);
    assign healthy   = ((&group_ok_reg) & ~i_valid_framing_error) | repair_ok;
    assign counting  = (state_reg == WAIT_START) || (state_reg == SEND_START) ||
                       (state_reg == POINT_TEST) || (state_reg == WAIT_ANY)   ||
                       (state_reg == WAIT_RD)    || (state_reg == SEND_LAST);

    sb_valid_arb u_arb (
        .clk          (clk),
        .rst          (rst),
        .clr          (~i_en),
        .load         (load_valid),
        .tx_valid     (i_tx_valid),
        .busy_negedge (i_busy_negedge_detected),
        .valid        (o_valid_rx),
        .valid_fall   (valid_fall)
    );

    // Next-state decode, message loads and the timeout override.
    always_comb begin
        state_next   = state_reg;
        load_msg     = 1'b0;
        load_valid   = 1'b0;
        msg_next     = NO_MSG;
        latch_groups = 1'b0;
        unique case (state_reg)
            IDLE: begin
                state_next = WAIT_START;
            end
            WAIT_START: begin
                if (req_valid && i_sideband_message == START_REQ) begin
                    load_msg   = 1'b1;
                    load_valid = 1'b1;
                    msg_next   = START_RESP;
                    state_next = SEND_START;
                end
            end
            SEND_START: begin
                if (valid_fall) begin
                    state_next = POINT_TEST;
                end
            end
            POINT_TEST: begin
                if (i_point_test_ack) begin
                    latch_groups = 1'b1;
                    state_next   = WAIT_ANY;
                end
            end
            WAIT_ANY: begin
                if (req_valid) begin
                    if (i_sideband_message == ERROR_REQ && !i_valid_framing_error) begin
                        load_msg   = 1'b1;
                        load_valid = 1'b1;
                        msg_next   = ERROR_RESP;
                        state_next = WAIT_RD;
                    end else if (i_sideband_message == EXIT_TO_PHYRETRAIN_REQ) begin
                        load_msg   = 1'b1;
                        load_valid = 1'b1;
                        msg_next   = EXIT_TO_PHYRETRAIN_RESP;
                        state_next = SEND_LAST;
                    end else if (i_sideband_message == DONE_REQ ||
                                 i_sideband_message == ERROR_REQ) begin
                        load_msg = 1'b1;
                        if (healthy) begin
                            load_valid = 1'b1;
                            msg_next   = DONE_RESP;
                            state_next = SEND_LAST;
                        end else begin
                            state_next = FINISH;
                        end
                    end
                end
            end
            WAIT_RD: begin
                if (req_valid) begin
                    if (i_sideband_message == EXIT_TO_SPEED_DEGRADE_REQ) begin
                        load_msg   = 1'b1;
                        load_valid = 1'b1;
                        msg_next   = EXIT_TO_SPEED_DEGRADE_RESP;
                        state_next = SEND_LAST;
                    end else if (i_sideband_message == EXIT_TO_REPAIR_REQ) begin
                        load_msg = 1'b1;
                        if (|group_ok_reg) begin
                            load_valid = 1'b1;
                            msg_next   = EXIT_TO_REPAIR_RESP;
                            state_next = SEND_LAST;
                        end else begin
                            state_next = FINISH;
                        end
                    end
                end
            end
            SEND_LAST: begin
                if (valid_fall) begin
                    state_next = FINISH;
                end
            end
            FINISH: begin
                state_next = FINISH;
            end
            TIMEOUT: begin
                state_next = TIMEOUT;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
        // A real transition in the last allowed cycle beats the timeout.
        if (counting && state_next == state_reg && cnt_reg == CNT_MAX) begin
            state_next = TIMEOUT;
        end
    end

    // State, timeout counter, response message and latched group mask.
    always_ff @(posedge clk) begin
        if (rst || !i_en) begin
            state_reg    <= IDLE;
            cnt_reg      <= '0;
            msg_reg      <= NO_MSG;
            group_ok_reg <= '0;
        end else begin
            state_reg <= state_next;
            if (state_next != state_reg) begin
                cnt_reg <= '0;
            end else if (counting) begin
                cnt_reg <= cnt_reg + 1'b1;
            end
            if (load_msg) begin
                msg_reg <= msg_next;
            end
            if (latch_groups) begin
                group_ok_reg <= group_pass;
            end
        end
    end

    assign o_sideband_message = msg_reg;
    assign o_point_test_en    = (state_reg == POINT_TEST);
    assign o_test_ack         = (state_reg == FINISH);
    assign o_timeout          = (state_reg == TIMEOUT);
    assign o_group_ok         = group_ok_reg;

endmodule

// File: tb/tb_linkspeed_rx_param.sv
// Directed bench for linkspeed_rx_param (16 lanes, 8-lane groups, 16-cycle timeout).
module tb_linkspeed_rx_param;

    logic        clk;
    logic        rst;
    logic        i_en;
    logic [3:0]  i_sideband_message;
    logic        i_sideband_valid;
    logic        i_tx_valid;
    logic        i_busy_negedge_detected;
    logic        i_point_test_ack;
    logic [15:0] i_lanes_result;
    logic        i_valid_framing_error;
    logic        i_comming_from_repair;
    logic [1:0]  i_tx_group_ok;
    logic [3:0]  o_sideband_message;
    logic        o_valid_rx;
    logic        o_point_test_en;
    logic        o_test_ack;
    logic        o_timeout;
    logic [1:0]  o_group_ok;

    int check_count = 0;
    int err_count   = 0;

    linkspeed_rx_param #(
        .NUM_LANES      (16),
        .GROUP_W        (8),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .clk                     (clk),
        .rst                     (rst),
        .i_en                    (i_en),
        .i_sideband_message      (i_sideband_message),
        .i_sideband_valid        (i_sideband_valid),
        .i_tx_valid              (i_tx_valid),
        .i_busy_negedge_detected (i_busy_negedge_detected),
        .i_point_test_ack        (i_point_test_ack),
        .i_lanes_result          (i_lanes_result),
        .i_valid_framing_error   (i_valid_framing_error),
        .i_comming_from_repair   (i_comming_from_repair),
        .i_tx_group_ok           (i_tx_group_ok),
        .o_sideband_message      (o_sideband_message),
        .o_valid_rx              (o_valid_rx),
        .o_point_test_en         (o_point_test_en),
        .o_test_ack              (o_test_ack),
        .o_timeout               (o_timeout),
        .o_group_ok              (o_group_ok)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance n edges; outputs are observed 1 time unit after the edge.
    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        check_count++;
        assert (obs === exp) else begin
            err_count++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
        $display("check %-16s observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, ".msg"},   32'(o_sideband_message), 32'h0);
        chk({tag, ".valid"}, 32'(o_valid_rx),         32'h0);
        chk({tag, ".pten"},  32'(o_point_test_en),    32'h0);
        chk({tag, ".ack"},   32'(o_test_ack),         32'h0);
        chk({tag, ".tmo"},   32'(o_timeout),          32'h0);
        chk({tag, ".grp"},   32'(o_group_ok),         32'h0);
    endtask

    task automatic send(input logic [3:0] code);
        i_sideband_message = code;
        i_sideband_valid   = 1'b1;
        step(1);
        i_sideband_valid   = 1'b0;
        i_sideband_message = 4'd0;
    endtask

    // Busy-negedge pulse, then one more edge for the falling-edge detect.
    task automatic busy_pulse();
        i_busy_negedge_detected = 1'b1;
        step(1);
        i_busy_negedge_detected = 1'b0;
        step(1);
    endtask

    // From WAIT_START: handshake START, then complete the point test.
    task automatic run_to_wait_any(input logic [15:0] lanes);
        send(4'd1);
        busy_pulse();
        i_lanes_result   = lanes;
        i_point_test_ack = 1'b1;
        step(1);
        i_point_test_ack = 1'b0;
    endtask

    task automatic restart();
        i_en = 1'b0;
        step(1);
        i_en = 1'b1;
        step(1);
    endtask

    initial begin
        rst = 1'b1;
        i_en = 1'b1;
        i_sideband_message = 4'd0;
        i_sideband_valid = 1'b0;
        i_tx_valid = 1'b0;
        i_busy_negedge_detected = 1'b0;
        i_point_test_ack = 1'b0;
        i_lanes_result = 16'h0;
        i_valid_framing_error = 1'b0;
        i_comming_from_repair = 1'b0;
        i_tx_group_ok = 2'b00;

        // Reset state, with i_en high (reset wins).
        step(2);
        chk_zero("reset");
        rst = 1'b0;
        step(1);

        // Full pass.
        send(4'd1);
        chk("pass.start_msg", 32'(o_sideband_message), 32'd2);
        chk("pass.start_vld", 32'(o_valid_rx), 32'd1);
        i_busy_negedge_detected = 1'b1;
        step(1);
        i_busy_negedge_detected = 1'b0;
        chk("pass.vld_fall", 32'(o_valid_rx), 32'd0);
        chk("pass.pten_pre", 32'(o_point_test_en), 32'd0);
        step(1);
        chk("pass.pten", 32'(o_point_test_en), 32'd1);
        i_lanes_result   = 16'hFFFF;
        i_point_test_ack = 1'b1;
        step(1);
        i_point_test_ack = 1'b0;
        chk("pass.pten_off", 32'(o_point_test_en), 32'd0);
        chk("pass.grp", 32'(o_group_ok), 32'h3);
        send(4'd9);
        chk("pass.done_msg", 32'(o_sideband_message), 32'd10);
        chk("pass.done_vld", 32'(o_valid_rx), 32'd1);
        chk("pass.ack_pre", 32'(o_test_ack), 32'd0);
        busy_pulse();
        chk("pass.ack", 32'(o_test_ack), 32'd1);
        step(2);
        chk("pass.ack_hold", 32'(o_test_ack), 32'd1);
        i_en = 1'b0;
        step(1);
        chk_zero("pass.en_low");
        i_en = 1'b1;
        step(1);

        // Error then speed degrade.
        run_to_wait_any(16'h00FF);
        chk("deg.grp", 32'(o_group_ok), 32'h1);
        send(4'd3);
        chk("deg.err_msg", 32'(o_sideband_message), 32'd4);
        chk("deg.err_vld", 32'(o_valid_rx), 32'd1);
        busy_pulse();
        chk("deg.err_off", 32'(o_valid_rx), 32'd0);
        send(4'd7);
        chk("deg.sd_msg", 32'(o_sideband_message), 32'd8);
        chk("deg.sd_vld", 32'(o_valid_rx), 32'd1);
        busy_pulse();
        chk("deg.ack", 32'(o_test_ack), 32'd1);
        chk("deg.grp_end", 32'(o_group_ok), 32'h1);
        restart();

        // Repair requested with no good group.
        run_to_wait_any(16'h7F7F);
        chk("rep.grp", 32'(o_group_ok), 32'h0);
        send(4'd3);
        chk("rep.err_msg", 32'(o_sideband_message), 32'd4);
        busy_pulse();
        send(4'd5);
        chk("rep.msg", 32'(o_sideband_message), 32'd0);
        chk("rep.vld", 32'(o_valid_rx), 32'd0);
        chk("rep.ack", 32'(o_test_ack), 32'd1);
        step(2);
        chk("rep.vld_late", 32'(o_valid_rx), 32'd0);
        restart();

        // Contention: TX side owns the sideband for 5 cycles.
        i_tx_valid = 1'b1;
        step(1);
        send(4'd1);
        chk("cont.msg", 32'(o_sideband_message), 32'd2);
        chk("cont.vld0", 32'(o_valid_rx), 32'd0);
        step(3);
        chk("cont.vld1", 32'(o_valid_rx), 32'd0);
        i_tx_valid = 1'b0;
        step(1);
        chk("cont.vld_rise", 32'(o_valid_rx), 32'd1);
        busy_pulse();
        chk("cont.pten", 32'(o_point_test_en), 32'd1);

        // Abort in POINT_TEST.
        i_en = 1'b0;
        step(1);
        chk_zero("abort");
        i_en = 1'b1;
        step(1);

        // Timeout: WAIT_START entered at the previous edge.
        chk("tmo.start", 32'(o_timeout), 32'd0);
        step(15);
        chk("tmo.pre", 32'(o_timeout), 32'd0);
        step(1);
        chk("tmo.hit", 32'(o_timeout), 32'd1);
        step(2);
        chk("tmo.hold", 32'(o_timeout), 32'd1);
        i_en = 1'b0;
        step(1);
        chk("tmo.clear", 32'(o_timeout), 32'd0);
        i_en = 1'b1;
        step(1);

        // Reset asserted in SEND_LAST.
        run_to_wait_any(16'hFFFF);
        send(4'd9);
        chk("rst.msg_pre", 32'(o_sideband_message), 32'd10);
        chk("rst.vld_pre", 32'(o_valid_rx), 32'd1);
        rst = 1'b1;
        step(1);
        chk_zero("rst_sl");
        rst = 1'b0;
        step(1);

        $display("CHECKS %0d ERRORS %0d", check_count, err_count);
        $finish;
    end

endmodule
